// File: rtl/fft_frame_buffer_if.sv
// Stream bundle for the FFT frame buffer: an upstream sample stream in and
// a framed sample stream out, plus the pending-frame count.
//
// Handshake: a sample moves on a rising clk edge exactly when valid and
// ready are both high in that cycle. The sender holds data (and last) stable
// while valid is high and ready is low. Ready may be high with valid low.
interface fft_frame_buffer_if #(
    parameter int DATA_WIDTH = 16
);
    logic [DATA_WIDTH-1:0] src_data_in;
    logic                  src_valid_in;
    logic                  src_ready_out;
    logic [DATA_WIDTH-1:0] dst_data_out;
    logic                  dst_valid_out;
    logic                  dst_ready_in;
    logic                  dst_last_out;
    logic [1:0]            frames_pending;

    // Environment side: produces samples, consumes frames.
    modport master (
        output src_data_in, src_valid_in, dst_ready_in,
        input  src_ready_out, dst_data_out, dst_valid_out, dst_last_out,
               frames_pending
    );

    // Buffer side.
    modport slave (
        input  src_data_in, src_valid_in, dst_ready_in,
        output src_ready_out, dst_data_out, dst_valid_out, dst_last_out,
               frames_pending
    );
endinterface

// File: rtl/fft_frame_buffer.sv
// Ping-pong frame buffer between the DDC sample stream and the FFT input.
// Two banks of N_POINTS samples: one fills while the other drains. A bank is
// released as a burst (bit-reversed or natural order) once it is full, and
// the writer stalls only when both banks hold unread frames.
module fft_frame_buffer #(
    parameter int DATA_WIDTH  = 16,
    parameter int N_POINTS    = 64,
    parameter bit BIT_REVERSE = 1'b1
) (
    input logic               clk,
    input logic               arst_n,
    input logic               flush,
    fft_frame_buffer_if.slave bus
);
    localparam int            AW       = $clog2(N_POINTS);
    localparam logic [AW-1:0] LAST_IDX = AW'(N_POINTS - 1);

    logic [DATA_WIDTH-1:0] mem [2][N_POINTS];
    logic [1:0]            full;
    logic                  wr_bank;
    logic                  rd_bank;
    logic [AW-1:0]         wr_cnt;
    logic [AW-1:0]         rd_cnt;
    logic [AW-1:0]         rd_idx;

    logic src_ready;
    logic dst_valid;
    logic wr_en;
    logic wr_done;
    logic rd_en;
    logic rd_done;

    function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] v);
        logic [AW-1:0] r;
        r = '0;
        for (int i = 0; i < AW; i++) begin
            r[i] = v[AW-1-i];
        end
        return r;
    endfunction

    // Handshake qualifiers; everything is derived from registered state so
    // the ready/valid outputs carry no combinational path from the peers.
    assign src_ready = arst_n & ~flush & ~full[wr_bank];
    assign dst_valid = arst_n & full[rd_bank];
    assign wr_en     = bus.src_valid_in & src_ready;
    assign wr_done   = wr_en & (wr_cnt == LAST_IDX);
    assign rd_en     = dst_valid & bus.dst_ready_in;
    assign rd_done   = rd_en & (rd_cnt == LAST_IDX);
    assign rd_idx    = BIT_REVERSE ? bitrev(rd_cnt) : rd_cnt;

    // Output stream; data is zeroed whenever no frame is on offer.
    always_comb begin
        bus.src_ready_out  = src_ready;
        bus.dst_valid_out  = dst_valid;
        bus.dst_data_out   = dst_valid ? mem[rd_bank][rd_idx] : '0;
        bus.dst_last_out   = dst_valid & (rd_cnt == LAST_IDX);
        bus.frames_pending = arst_n ? ({1'b0, full[0]} + {1'b0, full[1]}) : 2'd0;
    end

    // Sample storage, deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_bank][wr_cnt] <= bus.src_data_in;
        end
    end

    // Bank bookkeeping. A completing write and a completing read always hit
    // different banks (write needs full=0, read needs full=1), so both
    // updates to full can land in the same cycle.
    always_ff @(posedge clk) begin
        if (!arst_n) begin
            full    <= '0;
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
            wr_cnt  <= '0;
            rd_cnt  <= '0;
        end else begin
            if (flush) begin
                wr_cnt <= '0;
            end else if (wr_en) begin
                wr_cnt <= wr_cnt + AW'(1);
            end
            if (wr_done) begin
                full[wr_bank] <= 1'b1;
                wr_bank       <= ~wr_bank;
            end
            if (rd_en) begin
                rd_cnt <= rd_cnt + AW'(1);
            end
            if (rd_done) begin
                full[rd_bank] <= 1'b0;
                rd_bank       <= ~rd_bank;
            end
        end
    end
endmodule

// File: tb/tb_fft_frame_buffer.sv
// Bench for fft_frame_buffer: an 8-point bit-reversed instance exercised by
// directed scenarios against a frame-level model, and a 16-point natural
// order instance exercised with random traffic against an expected queue.
module tb_fft_frame_buffer;
    logic clk = 1'b0;
    logic rst_a_n, flush_a, rst_b_n, flush_b;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    fft_frame_buffer_if #(.DATA_WIDTH(16)) ifa ();
    fft_frame_buffer_if #(.DATA_WIDTH(16)) ifb ();

    fft_frame_buffer #(.DATA_WIDTH(16), .N_POINTS(8), .BIT_REVERSE(1'b1)) dut_a (
        .clk(clk), .arst_n(rst_a_n), .flush(flush_a), .bus(ifa.slave)
    );
    fft_frame_buffer #(.DATA_WIDTH(16), .N_POINTS(16), .BIT_REVERSE(1'b0)) dut_b (
        .clk(clk), .arst_n(rst_b_n), .flush(flush_b), .bus(ifb.slave)
    );

    // ---------------- frame-level model of the 8-point instance ----------------
    logic [15:0] a_out_q[$];   // completed frames, already in output order
    logic [15:0] a_cur_q[$];   // partially written frame, arrival order
    int          a_frames = 0;
    int          a_rd_pos = 0;
    logic [20:0] a_obs, a_exp; // {ready, valid, last, pending[1:0], data[15:0]}
    logic        a_acc, a_rd;
    logic [15:0] a_dout;

    function automatic int rev3(input int k);
        return ((k & 1) << 2) | (k & 2) | ((k & 4) >> 2);
    endfunction

    // One clock of the 8-point instance: drive, sample at negedge, advance model.
    task automatic cyc_a(input logic v, input logic [15:0] d, input logic rdy,
                         input logic fl, input logic rn);
        logic        e_ready, e_valid, e_last;
        logic [15:0] e_data;
        ifa.src_valid_in = v;
        ifa.src_data_in  = d;
        ifa.dst_ready_in = rdy;
        flush_a          = fl;
        rst_a_n          = rn;
        @(negedge clk);
        e_ready = rn && !fl && (a_frames < 2);
        e_valid = rn && (a_frames > 0);
        e_data  = e_valid ? a_out_q[0] : 16'h0;
        e_last  = e_valid && (a_rd_pos == 7);
        a_exp   = {e_ready, e_valid, e_last, (rn ? 2'(a_frames) : 2'd0), e_data};
        a_obs   = {ifa.src_ready_out, ifa.dst_valid_out, ifa.dst_last_out,
                   ifa.frames_pending, ifa.dst_data_out};
        a_acc   = v && e_ready;
        a_rd    = e_valid && rdy;
        a_dout  = ifa.dst_data_out;
        if (!rn) begin
            a_out_q.delete();
            a_cur_q.delete();
            a_frames = 0;
            a_rd_pos = 0;
        end else begin
            if (fl) a_cur_q.delete();
            if (a_acc) begin
                a_cur_q.push_back(d);
                if (a_cur_q.size() == 8) begin
                    for (int k = 0; k < 8; k++) a_out_q.push_back(a_cur_q[rev3(k)]);
                    a_cur_q.delete();
                    a_frames++;
                end
            end
            if (a_rd) begin
                void'(a_out_q.pop_front());
                a_rd_pos++;
                if (a_rd_pos == 8) begin
                    a_rd_pos = 0;
                    a_frames--;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        for (int c = 0; c < 3; c++) begin
            cyc_a(1'b0, 16'h0, 1'b0, 1'b0, (c == 2));
            checks++;
            if (a_obs !== a_exp) begin
                failures++;
                $display("FAIL reset c%0d: got %h want %h", c, a_obs, a_exp);
            end
        end
        checks++;
        if (a_obs[20] !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready_after_release: got %b want 1", a_obs[20]);
        end
    endtask

    task automatic test_bitrev();
        logic [15:0] want [8];
        logic [15:0] got[$];
        want = '{16'd0, 16'd4, 16'd2, 16'd6, 16'd1, 16'd5, 16'd3, 16'd7};
        for (int c = 0; c < 18; c++) begin
            if (c < 8) cyc_a(1'b1, 16'(c), 1'b1, 1'b0, 1'b1);
            else       cyc_a(1'b0, 16'h0, 1'b1, 1'b0, 1'b1);
            checks++;
            if (a_obs !== a_exp) begin
                failures++;
                $display("FAIL bitrev c%0d: got %h want %h", c, a_obs, a_exp);
            end
            if (c == 8) begin
                checks++;
                if (a_obs[19] !== 1'b1) begin
                    failures++;
                    $display("FAIL bitrev_latency: valid got %b want 1", a_obs[19]);
                end
            end
            if (a_rd) got.push_back(a_dout);
        end
        checks++;
        if (got.size() != 8) begin
            failures++;
            $display("FAIL bitrev_count: got %0d want 8", got.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (got[i] !== want[i]) begin
                    failures++;
                    $display("FAIL bitrev_order[%0d]: got %0d want %0d", i, got[i], want[i]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int idx = 0;
        int rd_n = 0;
        int c8 = -1;
        int c16 = -1;
        for (int c = 0; c < 24; c++) begin
            cyc_a(1'b1, 16'(200 + idx), 1'b0, 1'b0, 1'b1);
            checks++;
            if (a_obs !== a_exp) begin
                failures++;
                $display("FAIL bp_fill c%0d: got %h want %h", c, a_obs, a_exp);
            end
            if (a_acc) idx++;
        end
        checks++;
        if (idx != 16 || a_obs[20] !== 1'b0 || a_obs[17:16] !== 2'd2) begin
            failures++;
            $display("FAIL bp_full: accepted %0d ready %b pending %0d want 16 0 2",
                     idx, a_obs[20], a_obs[17:16]);
        end
        for (int c = 0; c < 40; c++) begin
            cyc_a(idx < 24, 16'(200 + idx), 1'b1, 1'b0, 1'b1);
            checks++;
            if (a_obs !== a_exp) begin
                failures++;
                $display("FAIL bp_drain c%0d: got %h want %h", c, a_obs, a_exp);
            end
            if (a_acc && idx == 16) c16 = c;
            if (a_acc) idx++;
            if (a_rd) begin
                rd_n++;
                if (rd_n == 8) c8 = c;
            end
        end
        checks++;
        if (c8 < 0 || c16 != c8 + 1 || rd_n != 24) begin
            failures++;
            $display("FAIL bp_resume: frame0 end c%0d sample16 c%0d reads %0d want c%0d and 24",
                     c8, c16, rd_n, c8 + 1);
        end
    endtask

    task automatic test_back_to_back();
        int n = 0;
        int reads = 0;
        int drops = 0;
        int first = -1;
        int last = -1;
        for (int c = 0; c < 44; c++) begin
            cyc_a(n < 32, 16'($urandom_range(0, 65535)), 1'b1, 1'b0, 1'b1);
            checks++;
            if (a_obs !== a_exp) begin
                failures++;
                $display("FAIL b2b c%0d: got %h want %h", c, a_obs, a_exp);
            end
            if (n < 32 && a_obs[20] !== 1'b1) drops++;
            if (a_acc) n++;
            if (a_rd) begin
                reads++;
                if (first < 0) first = c;
                last = c;
            end
        end
        checks++;
        if (reads != 32 || last - first != 31 || drops != 0 || first != 8) begin
            failures++;
            $display("FAIL b2b_stream: reads %0d span %0d drops %0d first c%0d want 32 31 0 c8",
                     reads, last - first, drops, first);
        end
    endtask

    task automatic test_flush();
        logic [15:0] want [8];
        logic [15:0] got[$];
        want = '{16'd100, 16'd104, 16'd102, 16'd106, 16'd101, 16'd105, 16'd103, 16'd107};
        for (int c = 0; c < 24; c++) begin
            if (c < 5)       cyc_a(1'b1, 16'($urandom_range(1000, 2000)), 1'b1, 1'b0, 1'b1);
            else if (c == 5) cyc_a(1'b1, 16'hdead, 1'b1, 1'b1, 1'b1);
            else if (c < 14) cyc_a(1'b1, 16'(100 + c - 6), 1'b1, 1'b0, 1'b1);
            else             cyc_a(1'b0, 16'h0, 1'b1, 1'b0, 1'b1);
            checks++;
            if (a_obs !== a_exp) begin
                failures++;
                $display("FAIL flush c%0d: got %h want %h", c, a_obs, a_exp);
            end
            if (a_rd) got.push_back(a_dout);
        end
        checks++;
        if (got.size() != 8) begin
            failures++;
            $display("FAIL flush_count: got %0d want 8", got.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (got[i] !== want[i]) begin
                    failures++;
                    $display("FAIL flush_order[%0d]: got %0d want %0d", i, got[i], want[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int reads = 0;
        for (int c = 0; c < 12; c++) begin
            cyc_a(1'b1, 16'(300 + c), (c >= 8), 1'b0, 1'b1);
            checks++;
            if (a_obs !== a_exp) begin
                failures++;
                $display("FAIL rmid_fill c%0d: got %h want %h", c, a_obs, a_exp);
            end
        end
        cyc_a(1'b1, 16'h1234, 1'b1, 1'b0, 1'b0);
        checks++;
        if (a_obs !== a_exp) begin
            failures++;
            $display("FAIL rmid_during: got %h want %h", a_obs, a_exp);
        end
        cyc_a(1'b0, 16'h0, 1'b1, 1'b0, 1'b1);
        checks++;
        if (a_obs[20:16] !== 5'b10000) begin
            failures++;
            $display("FAIL rmid_after: ready/valid/last/pending got %b want 10000", a_obs[20:16]);
        end
        for (int c = 0; c < 20; c++) begin
            cyc_a(c < 8, 16'(400 + c), 1'b1, 1'b0, 1'b1);
            checks++;
            if (a_obs !== a_exp) begin
                failures++;
                $display("FAIL rmid_fresh c%0d: got %h want %h", c, a_obs, a_exp);
            end
            if (a_rd) reads++;
        end
        checks++;
        if (reads != 8) begin
            failures++;
            $display("FAIL rmid_fresh_reads: got %0d want 8", reads);
        end
    endtask

    // 16-point natural order: output sequence must equal input sequence.
    task automatic test_random_natural();
        logic [15:0] exp_q[$];
        int          sent = 0;
        int          recv = 0;
        logic        pv = 1'b0;
        logic        pr = 1'b0;
        logic        pl = 1'b0;
        logic [15:0] pd = 16'h0;
        logic        v, r;
        logic [15:0] d, w;
        rst_b_n = 1'b0;
        flush_b = 1'b0;
        ifb.src_valid_in = 1'b0;
        ifb.src_data_in  = 16'h0;
        ifb.dst_ready_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_b_n = 1'b1;
        for (int c = 0; c < 20000 && recv < 1600; c++) begin
            v = (sent < 1600) && ($urandom_range(0, 1) == 1);
            d = 16'($urandom_range(0, 65535));
            r = ($urandom_range(0, 1) == 1);
            ifb.src_valid_in = v;
            ifb.src_data_in  = d;
            ifb.dst_ready_in = r;
            @(negedge clk);
            checks++;
            if (ifb.frames_pending > 2'd2) begin
                failures++;
                $display("FAIL rnd_pending: got %0d want <=2", ifb.frames_pending);
            end
            if (pv && !pr) begin
                checks++;
                if ({ifb.dst_valid_out, ifb.dst_last_out, ifb.dst_data_out} !== {1'b1, pl, pd}) begin
                    failures++;
                    $display("FAIL rnd_stall_hold: got %b %b %h want 1 %b %h",
                             ifb.dst_valid_out, ifb.dst_last_out, ifb.dst_data_out, pl, pd);
                end
            end
            if (v && ifb.src_ready_out) begin
                exp_q.push_back(d);
                sent++;
            end
            if (ifb.dst_valid_out && r) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL rnd_spurious: got %h want no data", ifb.dst_data_out);
                end else begin
                    w = exp_q.pop_front();
                    if (ifb.dst_data_out !== w || ifb.dst_last_out !== (recv % 16 == 15)) begin
                        failures++;
                        $display("FAIL rnd_data #%0d: got %h last %b want %h last %b",
                                 recv, ifb.dst_data_out, ifb.dst_last_out, w, (recv % 16 == 15));
                    end
                end
                recv++;
            end
            pv = ifb.dst_valid_out;
            pr = r;
            pl = ifb.dst_last_out;
            pd = ifb.dst_data_out;
            @(posedge clk);
            #1;
        end
        checks++;
        if (recv != 1600 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL rnd_total: received %0d left %0d want 1600 0", recv, exp_q.size());
        end
    endtask

    initial begin
        rst_b_n = 1'b0;
        flush_b = 1'b0;
        ifb.src_valid_in = 1'b0;
        ifb.src_data_in  = 16'h0;
        ifb.dst_ready_in = 1'b0;
        test_reset();
        test_bitrev();
        test_backpressure();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        test_random_natural();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fft_frame_buffer.md
Name: fft_frame_buffer

Overview:
- Ping-pong frame buffer between the decimator (DDC) output stream and the FFT input stream of the DSP core.
- Collects N_POINTS consecutive samples into one of two banks. Releases each completed frame as a burst, in bit-reversed or natural order, with a last-sample marker.
- Both sides use valid/ready streaming. Full throughput once primed; backpressure is applied upstream only when both banks hold unread frames.

Parameters:
- DATA_WIDTH, 16: sample width in bits.
- N_POINTS, 64: frame length; power of two, >= 4.
- BIT_REVERSE, 1: 1 = output index is the bit-reversed read counter; 0 = natural order.

Ports:
- clk  input  1  core clock.
- arst_n  input  1  reset, synchronous, active-low.
- flush  input  1  synchronous; discards the partially written frame.
- src_data_in  input  DATA_WIDTH  upstream sample.
- src_valid_in  input  1  upstream sample valid.
- src_ready_out  output  1  buffer can accept a sample.
- dst_data_out  output  DATA_WIDTH  frame sample to the FFT.
- dst_valid_out  output  1  dst_data_out valid.
- dst_ready_in  input  1  FFT accepts the sample.
- dst_last_out  output  1  marks the final sample of a frame.
- frames_pending  output  2  number of complete, unread frames (0..2).

Behaviour:
- State:
  - mem[2][N_POINTS] register array; memory is not reset.
  - full[1:0] flags.
  - wr_bank, rd_bank: 1 bit each.
  - wr_cnt, rd_cnt: log2(N_POINTS) bits each.
- Reset (arst_n=0 at a clk edge):
  - full=0; wr_bank=rd_bank=0; wr_cnt=rd_cnt=0.
  - While arst_n=0: src_ready_out=0, dst_valid_out=0, dst_last_out=0, dst_data_out=0, frames_pending=0.
  - Reset mid-frame or mid-drain discards everything. src_ready_out=1 on the first cycle after release.
- src_ready_out = arst_n & ~flush & ~full[wr_bank] (combinational from state).
- Write on src_valid_in & src_ready_out:
  - mem[wr_bank][wr_cnt] <= src_data_in; wr_cnt++.
  - If wr_cnt==N_POINTS-1: full[wr_bank]<=1, wr_bank toggles, wr_cnt wraps to 0.
- dst_valid_out = full[rd_bank].
- dst_data_out = mem[rd_bank][idx], where idx = bitrev(rd_cnt) if BIT_REVERSE else rd_cnt. Forced to 0 when dst_valid_out=0.
- dst_last_out = dst_valid_out & (rd_cnt==N_POINTS-1).
- Read transfer on dst_valid_out & dst_ready_in: rd_cnt++. On the last sample: full[rd_bank]<=0, rd_bank toggles, rd_cnt wraps.
- Latency: the frame completing write at edge k gives dst_valid_out=1 in the cycle after edge k (1 cycle), with first sample mem[.][idx(0)] = sample 0.
- Simultaneous write-complete and read-complete always target different banks, because a write needs full=0 and a read needs full=1. Both updates apply in the same cycle, so continuous streaming has no bubbles.
- A read that frees a bank does not raise src_ready_out in the same cycle; it rises in the next cycle (1-cycle bubble when both banks were full).
- frames_pending = full[0] + full[1].
- dst_data_out, dst_last_out and idx are held stable while dst_valid_out=1 and dst_ready_in=0.
- flush=1:
  - wr_cnt<=0; any sample presented that cycle is not accepted.
  - Completed frames (full banks) and the read side are unaffected.
  - Flush with wr_cnt=0 is a no-op.
- Data is stored and forwarded unmodified; no arithmetic on samples.

Test Plan:
- N_POINTS=8, BIT_REVERSE=1, dst_ready_in=1, feed 0..7 back-to-back -> dst_valid_out rises the cycle after the 8th accept; outputs 0,4,2,6,1,5,3,7 on consecutive cycles; dst_last_out only with 7.
- N_POINTS=8, dst_ready_in=0, stream 24 samples -> exactly 16 accepted, then src_ready_out=0 and frames_pending=2. Raise dst_ready_in -> frame 0 then frame 1 drain in order. src_ready_out returns 1 one cycle after frame 0's last transfer; sample 16 accepted next.
- N_POINTS=8, both ready high, 4 frames continuous -> src_ready_out never drops. After the first 1-cycle latency, 32 outputs appear with no gaps; dst_last_out every 8th.
- Write 5 samples, pulse flush with src_valid_in=1, then write 8 more (100..107) -> the first 5 and the flush-cycle sample never appear; output frame is 100,104,102,106,101,105,103,107.
- Assert arst_n=0 for 1 cycle while frame 0 is half drained and frame 1 half written -> next cycle dst_valid_out=0 and frames_pending=0. After release, src_ready_out=1 and a fresh frame completes normally.
- BIT_REVERSE=0, N_POINTS=16, random src_valid_in/dst_ready_in (50%), 100 frames -> scoreboard shows natural order and no loss or duplication. dst_data_out is stable under stall; frames_pending never exceeds 2.
